// File: rtl/waveform_playback_pkg.sv
// Shared definitions for the waveform playback / acquisition blocks:
// CSR bit positions, controller states and width-derivation helpers.
package waveform_playback_pkg;

  localparam int CSR_ARM        = 31;
  localparam int CSR_SOFT_TRIG  = 30;
  localparam int CSR_SET_PTR    = 29;
  localparam int CSR_ABORT      = 28;
  localparam int CSR_CONTINUOUS = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } state_t;

  function automatic int addr_width(input int capacity, input int samples_per_clock);
    return $clog2(capacity / samples_per_clock);
  endfunction

  // Never zero so that lane-select slices stay legal with one sample per word.
  function automatic int sidx_width(input int samples_per_clock);
    return (samples_per_clock > 1) ? $clog2(samples_per_clock) : 1;
  endfunction

  function automatic int pass_width(input int max_passes);
    return $clog2(max_passes) + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready register slice. flush discards every buffered word
// except one already being presented, which stays put until it is accepted.
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & ~flush & ((count != 2'd2) | pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= (out_valid && !pop) ? 2'd1 : 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload registers are qualified by count, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
        end
        2'b01: head <= tail;
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/waveform_playback.sv
// DAC waveform playback: GPIO-loaded sample RAM streamed out over AXI-stream
// on trigger, for a programmed number of passes or continuously.
module waveform_playback
  import waveform_playback_pkg::*;
#(
  parameter int SAMPLE_CAPACITY         = 4096,
  parameter int MAX_PASSES_PER_PLAYBACK = 1024,
  parameter int AXI_SAMPLES_PER_CLOCK   = 2,
  parameter int AXI_SAMPLE_WIDTH        = 16,
  parameter int DAC_WIDTH               = 14
) (
  input  logic                                          sysClk,
  input  logic                                          sysReset_n,
  input  logic                                          sysCsrStrobe,
  input  logic                                          sysDataStrobe,
  input  logic [31:0]                                   GPIO_OUT,
  input  logic                                          sysTrigger,
  output logic [31:0]                                   sysStatusReg,
  output logic                                          axiValid,
  input  logic                                          axiReady,
  output logic [AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] axiData,
  output logic                                          axiLast,
  output logic                                          playing
);

  localparam int ADDR_W = addr_width(SAMPLE_CAPACITY, AXI_SAMPLES_PER_CLOCK);
  localparam int SIDX_W = sidx_width(AXI_SAMPLES_PER_CLOCK);
  localparam int PASS_W = pass_width(MAX_PASSES_PER_PLAYBACK);
  localparam int PTR_W  = ADDR_W + SIDX_W;
  localparam int DEPTH  = SAMPLE_CAPACITY / AXI_SAMPLES_PER_CLOCK;
  localparam int SW     = AXI_SAMPLE_WIDTH;
  localparam int WORD_W = AXI_SAMPLES_PER_CLOCK * SW;
  localparam logic [SW-1:0] SAMPLE_MASK = ~((SW'(1) << (SW - DAC_WIDTH)) - SW'(1));

  state_t              state, state_next;
  logic                armed;
  logic [ADDR_W-1:0]   word_reload;
  logic [PASS_W-1:0]   pass_reload;
  logic                continuous;
  logic                load_error;
  logic [PTR_W-1:0]    load_ptr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     word_cnt;
  logic [ADDR_W:0]     word_next;
  logic [PASS_W-1:0]   pass_cnt;
  logic                rd_pending;
  logic                rd_last;
  logic                aborting;
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W:0]     buf_data;
  logic [1:0]          buf_count;
  logic [2:0]          occupancy;
  logic                csr_arm, csr_soft, csr_set_ptr, csr_abort;
  logic                arm_ok, start, load_we, issue, pass_end, push, pop, flush, drain;
  logic                play_done, abort_done;
  logic                unused_gpio;

  assign csr_set_ptr = sysCsrStrobe & GPIO_OUT[CSR_SET_PTR];
  assign csr_abort   = sysCsrStrobe & GPIO_OUT[CSR_ABORT];
  assign csr_arm     = sysCsrStrobe & GPIO_OUT[CSR_ARM] & ~GPIO_OUT[CSR_SET_PTR];
  assign csr_soft    = sysCsrStrobe & GPIO_OUT[CSR_SOFT_TRIG] & ~GPIO_OUT[CSR_SET_PTR];
  assign unused_gpio = ^GPIO_OUT;

  assign arm_ok  = (state == IDLE) & csr_arm;
  assign start   = (state == ARMED) & ~csr_abort & (sysTrigger | csr_soft);
  assign load_we = (state == IDLE) & sysDataStrobe;
  assign drain   = csr_abort | aborting;
  assign pop     = axiValid & axiReady;
  assign flush   = (state == PLAY) & csr_abort;

  // Fetch only when the skid buffer is guaranteed room for the word once the
  // one-cycle RAM read returns, counting any read already in flight.
  assign occupancy = {1'b0, buf_count} + {2'b0, rd_pending} - {2'b0, pop};
  assign issue     = (state == PLAY) & ~drain & ~pass_cnt[PASS_W-1] & (occupancy < 3'd2);
  assign word_next = word_cnt - (ADDR_W+1)'(1);
  assign pass_end  = word_next[ADDR_W];
  assign push      = rd_pending & (state == PLAY) & ~drain;

  assign play_done  = pass_cnt[PASS_W-1] & ~rd_pending &
                      ((buf_count == 2'd0) | ((buf_count == 2'd1) & pop));
  assign abort_done = ~axiValid | pop;

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) state <= IDLE;
    else             state <= state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (arm_ok) state_next = ARMED;
      ARMED: begin
        if (csr_abort)  state_next = IDLE;
        else if (start) state_next = PLAY;
      end
      PLAY: begin
        if (drain) begin
          if (abort_done) state_next = IDLE;
        end else if (play_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    armed   = (state == ARMED);
    playing = (state == PLAY);
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      word_reload <= '0;
      pass_reload <= '0;
      continuous  <= 1'b0;
      load_error  <= 1'b0;
      load_ptr    <= '0;
      rd_addr     <= '0;
      word_cnt    <= '0;
      pass_cnt    <= '0;
      rd_pending  <= 1'b0;
      rd_last     <= 1'b0;
      aborting    <= 1'b0;
    end else begin
      if (csr_set_ptr)  load_ptr <= GPIO_OUT[PTR_W-1:0];
      else if (load_we) load_ptr <= load_ptr + PTR_W'(1);

      if (arm_ok) begin
        word_reload <= GPIO_OUT[0 +: ADDR_W];
        pass_reload <= GPIO_OUT[ADDR_W +: PASS_W];
        continuous  <= GPIO_OUT[CSR_CONTINUOUS];
        load_error  <= 1'b0;
      end else if (sysDataStrobe && state != IDLE) begin
        load_error  <= 1'b1;
      end

      if (start) begin
        rd_addr  <= '0;
        word_cnt <= {1'b0, word_reload};
        pass_cnt <= pass_reload;
      end else if (issue) begin
        if (pass_end) begin
          rd_addr  <= '0;
          word_cnt <= {1'b0, word_reload};
          if (!continuous) pass_cnt <= pass_cnt - PASS_W'(1);
        end else begin
          rd_addr  <= rd_addr + ADDR_W'(1);
          word_cnt <= word_next;
        end
      end

      rd_pending <= issue;
      if (issue) rd_last <= pass_end;
      aborting <= (state_next == PLAY) & drain;
    end
  end

  for (genvar g = 0; g < AXI_SAMPLES_PER_CLOCK; g++) begin : g_lane
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] q;
    // NOTE: the sample RAM has no reset so it maps onto block RAM; a loaded
    // waveform survives sysReset_n.
    always_ff @(posedge sysClk) begin
      if (load_we && load_ptr[SIDX_W-1:0] == SIDX_W'(g))
        mem[load_ptr[SIDX_W +: ADDR_W]] <= GPIO_OUT[SW-1:0] & SAMPLE_MASK;
      if (issue) q <= mem[rd_addr];
    end
    assign rd_word[g*SW +: SW] = q;
  end

  axis_skid_buffer #(.WIDTH(WORD_W + 1)) u_skid (
    .clk       (sysClk),
    .rst_n     (sysReset_n),
    .flush     (flush),
    .in_valid  (push),
    .in_data   ({rd_last, rd_word}),
    .out_valid (axiValid),
    .out_ready (axiReady),
    .out_data  (buf_data),
    .count     (buf_count)
  );

  assign axiData = buf_data[WORD_W-1:0];
  assign axiLast = buf_data[WORD_W];

  always_comb begin
    sysStatusReg                    = '0;
    sysStatusReg[31]                = armed | playing;
    sysStatusReg[30]                = playing;
    sysStatusReg[29]                = load_error;
    sysStatusReg[28]                = continuous;
    sysStatusReg[ADDR_W +: PASS_W]  = pass_reload;
    sysStatusReg[0 +: ADDR_W]       = word_reload;
  end

endmodule

// File: doc/waveform_playback.md
Name: waveform_playback

Overview:
- Transmit-side counterpart of the BCM acquisition path: processor loads a DAC waveform into on-chip RAM through GPIO strobes, arms, then on trigger streams it as AXI-stream DAC samples.
- Supports multi-pass and continuous playback.
- Sits between the processor GPIO/CSR bus and the DAC AXI-stream input; CDC to the DAC clock is handled downstream by the AXI FIFO.

Parameters:
- SAMPLE_CAPACITY, 4096: samples stored; power of 2, multiple of AXI_SAMPLES_PER_CLOCK.
- MAX_PASSES_PER_PLAYBACK, 1024: power of 2.
- AXI_SAMPLES_PER_CLOCK, 2: samples per AXI word, power of 2.
- AXI_SAMPLE_WIDTH, 16: bits per AXI sample field.
- DAC_WIDTH, 14: DAC resolution; ≤ AXI_SAMPLE_WIDTH.

Ports:
- sysClk  in  1  sole clock.
- sysReset_n  in  1  async active-low reset.
- sysCsrStrobe  in  1  GPIO_OUT holds control word.
- sysDataStrobe  in  1  GPIO_OUT holds sample to load.
- GPIO_OUT  in  32  processor data.
- sysTrigger  in  1  start pulse, already synchronous to sysClk (EVR event).
- sysStatusReg  out  32  status readback.
- axiValid  out  1  AXI-stream valid.
- axiReady  in  1  AXI-stream ready.
- axiData  out  AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH  sample 0 in LSBs.
- axiLast  out  1  last word of a pass.
- playing  out  1  high in PLAY state.

Behaviour:
- Derived widths:
  - ADDR_W = clog2(SAMPLE_CAPACITY/AXI_SAMPLES_PER_CLOCK).
  - SIDX_W = clog2(AXI_SAMPLES_PER_CLOCK); min 1 for slices.
  - PASS_W = clog2(MAX_PASSES_PER_PLAYBACK) + 1.
- Reset: state IDLE; all outputs, counters, reload regs and loadError are 0. RAM is not reset.
- CSR word fields:
  - bit31 arm, bit30 soft trigger, bit29 set load pointer, bit28 abort, bit27 continuous.
  - [0+:ADDR_W] wordReload.
  - [ADDR_W+:PASS_W] passReload.
  - For bit29 only: load pointer = GPIO_OUT[0+:ADDR_W+SIDX_W]; the other fields are ignored.
- Load:
  - sysDataStrobe in IDLE writes GPIO_OUT[AXI_SAMPLE_WIDTH-1 -: DAC_WIDTH] (left-adjusted) into the slot at the load pointer, then increments the pointer.
  - The pointer wraps modulo SAMPLE_CAPACITY.
  - sysDataStrobe outside IDLE is ignored and sets loadError (sticky; cleared by the next arm).
- States:
  - IDLE: bit31 → latch wordReload, passReload, continuous; go to ARMED next cycle.
  - ARMED: sysTrigger, or CSR bit30 → go to PLAY. A trigger in IDLE or PLAY is ignored and not remembered. A trigger in the same cycle as arm is ignored.
  - PLAY: each pass emits wordReload+1 words from RAM addresses 0..wordReload. After passReload+1 passes (or never, if continuous), go to IDLE.
  - Abort (bit28), from any state:
    - Stop fetching and discard buffered words.
    - A word already presented with axiValid is held until the handshake, then axiValid drops.
    - Go to IDLE after that handshake, or immediately if no word is presented.
- Stream rules:
  - axiValid rises no later than 3 cycles after the trigger cycle.
  - With axiReady held high: one word per cycle, no bubbles within or between passes.
  - While axiValid && !axiReady: axiData, axiLast and axiValid are held stable.
  - The RAM address advances only as buffer space frees. RAM has 1-cycle registered read; a 2-entry skid buffer covers the latency.
  - axiLast = 1 on the word from address wordReload, every pass.
  - wordReload = 0 means every word is last.
- Counters:
  - Word counter is a down-counter with an ADDR_W+1 bit underflow flag.
  - Pass counter is PASS_W bits; MSB set = done. passReload = 0 means one pass.
- playing falls in the cycle after the final handshake.
- sysStatusReg:
  - bit31 armed|playing, bit30 playing, bit29 loadError, bit28 continuous.
  - [ADDR_W+:PASS_W] passReload, [0+:ADDR_W] wordReload; other bits 0.
- Reset mid-PLAY: asynchronously clears axiValid and returns to IDLE.

Decomposition:
- Shared package holds:
  - CSR bit positions (ARM, SOFT_TRIG, SET_PTR, ABORT, CONTINUOUS).
  - State enum IDLE/ARMED/PLAY.
  - Width-derivation functions, reused by the acquisition block.
- One sub-module is natural: axis_skid_buffer, a 2-entry valid/ready register slice with flush input, data width parameterised.

Test Plan:
- Load 8 samples 0x0004,0x0008,…,0x0020 (DAC_WIDTH 14, pointer 0), arm wordReload=3 passReload=0, soft trigger, axiReady=1 → 4 words, each word's two samples {0x0004,0x0008}, {0x000C,0x0010}, …; axiLast only on word 4; then IDLE, status bit31=0.
- Same waveform, passReload=2, axiReady=1 → 12 contiguous valid cycles; axiLast on cycles 4, 8, 12; playing low after the 12th.
- Random axiReady (50%) over 3 passes → received sequence identical to the ready=1 case; data stable during every stall cycle.
- Continuous mode, abort issued mid-pass with axiReady=0 → presented word held until ready; exactly one more handshake; then axiValid=0 and IDLE.
- sysDataStrobe during PLAY → RAM unchanged, status bit29=1; next arm clears it. sysTrigger in IDLE, then arm → stays ARMED with no output.
- Assert sysReset_n=0 mid-PLAY → axiValid, playing and status go to 0 immediately; after release the previously loaded waveform replays correctly on arm+trigger.
